// File: rtl/acsi_sector_seq.sv
// -----------------------------------------------------------------------------
// acsi_sector_seq
//
// Sector sequencer between the ACSI command block and the SD card / DMA back
// end. It accepts one read or write request per unit, runs the SD transfer for
// each sector and waits for the DMA sector handshake. It then answers upstream
// with next or done, so that multi-sector commands stream without CPU help.
//
// Parameters
//   TIMEOUT_W      watchdog width; the watchdog fires when the counter is all-ones
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high
//   req_rd[1:0]    read request per unit (level, held until busy)
//   req_wr[1:0]    write request per unit (level, held until busy)
//   req_lba        LBA of the requested sector
//   req_length     remaining sectors including this one
//   busy           1-cycle pulse: request accepted
//   next           1-cycle pulse: sector finished, more sectors remain
//   done           1-cycle pulse: whole transfer finished (ok or error)
//   err            sticky error flag, cleared by the next accepted first request
//   sd_rd[1:0]     SD read strobe per unit, held until sd_busy
//   sd_wr[1:0]     SD write strobe per unit, held until sd_busy
//   sd_lba         LBA presented to the SD controller
//   sd_busy        SD controller accepted the strobe
//   sd_done        1-cycle pulse: SD sector transfer complete
//   dma_sec_ack    1-cycle pulse: DMA moved one sector between FIFO and RAM
//   dma_scnt_zero  Atari DMA sector count exhausted
//   sectors_done   sectors completed in the current transfer
// -----------------------------------------------------------------------------
module acsi_sector_seq #(
  parameter int TIMEOUT_W = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba,
  input  logic [15:0] req_length,
  output logic        busy,
  output logic        next,
  output logic        done,
  output logic        err,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  output logic [31:0] sd_lba,
  input  logic        sd_busy,
  input  logic        sd_done,
  input  logic        dma_sec_ack,
  input  logic        dma_scnt_zero,
  output logic [15:0] sectors_done
);

  typedef enum logic [2:0] {
    IDLE,
    WR_DMA,
    SD_REQ,
    SD_XFER,
    RD_DMA,
    DECIDE,
    NEXT_WAIT
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic                 unit_q;      // latched unit (0/1)
  logic                 dir_rd_q;    // latched direction: 1 = read
  logic [15:0]          remaining;
  logic [TIMEOUT_W-1:0] wd;

  // Arbitration: read beats write, unit 0 beats unit 1.
  logic       any_req;
  logic       arb_rd;
  logic       arb_unit;
  logic [1:0] unit_mask;
  logic       strobe_on;
  logic       same_req;
  logic       timeout;
  logic [15:0] rem_dec;

  assign any_req   = (|req_rd) | (|req_wr);
  assign arb_rd    = |req_rd;
  assign arb_unit  = arb_rd ? ~req_rd[0] : ~req_wr[0];
  assign unit_mask = unit_q ? 2'b10 : 2'b01;
  assign strobe_on = (|sd_rd) | (|sd_wr);
  // Only a request from the unit and direction already in progress may
  // continue the transfer; everything else waits until IDLE.
  assign same_req  = dir_rd_q ? req_rd[unit_q] : req_wr[unit_q];
  assign timeout   = (state != IDLE) && (&wd);
  assign rem_dec   = remaining - 16'd1;

  logic accept_first;
  logic accept_cont;
  logic busy_nx;
  logic next_nx;
  logic done_nx;
  logic strobe_hold;

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nx     = state;
    accept_first = 1'b0;
    accept_cont  = 1'b0;
    busy_nx      = 1'b0;
    next_nx      = 1'b0;
    done_nx      = 1'b0;

    case (state)
      IDLE: begin
        // While busy is high, upstream has not yet dropped the request it
        // just had accepted, so that request must not be taken a second time.
        if (any_req && !busy) begin
          accept_first = 1'b1;
          busy_nx      = 1'b1;
          if (req_length == 16'd0) done_nx = 1'b1;
          else                     state_nx = arb_rd ? SD_REQ : WR_DMA;
        end
      end
      WR_DMA:  if (dma_sec_ack)            state_nx = SD_REQ;
      // A sd_busy that arrives before the strobe is up is not an acceptance.
      SD_REQ:  if (strobe_on && sd_busy)   state_nx = SD_XFER;
      // A dma_sec_ack in the same cycle as sd_done is lost on purpose.
      SD_XFER: if (sd_done)                state_nx = dir_rd_q ? RD_DMA : DECIDE;
      RD_DMA:  if (dma_sec_ack)            state_nx = DECIDE;
      DECIDE: begin
        if (rem_dec == 16'd0 || dma_scnt_zero) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          next_nx  = 1'b1;
          state_nx = NEXT_WAIT;
        end
      end
      NEXT_WAIT: begin
        if (same_req) begin
          accept_cont = 1'b1;
          busy_nx     = 1'b1;
          state_nx    = dir_rd_q ? SD_REQ : WR_DMA;
        end
      end
      default: state_nx = IDLE;
    endcase

    // The watchdog aborts the transfer from any waiting state.
    if (timeout) begin
      state_nx    = IDLE;
      accept_cont = 1'b0;
      busy_nx     = 1'b0;
      next_nx     = 1'b0;
      done_nx     = 1'b1;
    end

    // The strobe rises one cycle after SD_REQ is entered. It stays up until
    // SD_REQ is left, through either acceptance or the watchdog.
    strobe_hold = (state == SD_REQ) && (state_nx == SD_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      unit_q       <= 1'b0;
      dir_rd_q     <= 1'b0;
      remaining    <= '0;
      wd           <= '0;
      busy         <= 1'b0;
      next         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      sd_rd        <= 2'b00;
      sd_wr        <= 2'b00;
      sd_lba       <= '0;
      sectors_done <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so that every register samples
      // the values from before the edge whatever the statement order.
      state <= state_nx;
      busy  <= busy_nx;
      next  <= next_nx;
      done  <= done_nx;
      sd_rd <= (strobe_hold &&  dir_rd_q) ? unit_mask : 2'b00;
      sd_wr <= (strobe_hold && !dir_rd_q) ? unit_mask : 2'b00;

      // The watchdog restarts on every state change and is idle in IDLE.
      if (state == IDLE || state_nx != state) wd <= '0;
      else                                    wd <= wd + 1'b1;

      if (accept_first) begin
        unit_q       <= arb_unit;
        dir_rd_q     <= arb_rd;
        remaining    <= req_length;
        sd_lba       <= req_lba;
        err          <= 1'b0;
        sectors_done <= '0;
      end

      // A continuation request carries a new LBA only. The remaining count
      // stays the one latched with the first request.
      if (accept_cont) sd_lba <= req_lba;

      if (state == DECIDE) begin
        if (remaining != 16'd0)       remaining    <= rem_dec;
        if (sectors_done != 16'hFFFF) sectors_done <= sectors_done + 16'd1;
      end

      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acsi_sector_seq.sv
// -----------------------------------------------------------------------------
// tb_acsi_sector_seq
//
// Bench for acsi_sector_seq. The stimulus tasks act as both the upstream ACSI
// block and the SD/DMA back end. For each transfer the reference model lists
// the ordered events the sequencer must produce: busy, DMA acks, SD strobes,
// next and done, each with the expected LBA, sector count and error flag. The
// list is pushed into a queue. A monitor samples on the falling edge, pops one
// entry for every event it observes and compares the two.
// -----------------------------------------------------------------------------
module tb_acsi_sector_seq;

  localparam int TW = 6;  // watchdog width; fires 63 cycles after a state change

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_lba;
  logic [15:0] req_length;
  logic        busy, next, done, err;
  logic [1:0]  sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic        sd_busy, sd_done, dma_sec_ack, dma_scnt_zero;
  logic [15:0] sectors_done;

  acsi_sector_seq #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_length(req_length),
    .busy(busy), .next(next), .done(done), .err(err),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba),
    .sd_busy(sd_busy), .sd_done(sd_done),
    .dma_sec_ack(dma_sec_ack), .dma_scnt_zero(dma_scnt_zero),
    .sectors_done(sectors_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fixed_dly = -1;   // >= 0 forces every back-end delay to that value

  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_BUSY, EV_ACK, EV_STROBE, EV_NEXT, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] lba;
    logic [15:0] scount;
    logic        err;
    int          dly;     // required cycles from strobe to this event, -1 = any
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(ev_kind_t k, logic [1:0] rd, logic [1:0] wr,
                             logic [31:0] lba, logic [15:0] sc, logic e, int d);
    ev_t ev;
    ev.kind = k; ev.rd = rd; ev.wr = wr; ev.lba = lba;
    ev.scount = sc; ev.err = e; ev.dly = d;
    return ev;
  endfunction

  // ---------------------------------------------------------------- monitor
  bit          strobe_prev = 0;
  int          strobe_cyc  = 0;
  bit          cur_valid   = 0;
  logic [31:0] cur_lba     = '0;

  task automatic observe(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_%s actual=event required=none (cycle %0d)", k.name(), cyc);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("event_kind_%s", e.kind.name()), 64'(k), 64'(e.kind));
    if (k != e.kind) return;
    case (k)
      EV_BUSY: begin
        check("busy_sectors_done", sectors_done, e.scount);
        check("busy_err", err, e.err);
      end
      EV_STROBE: begin
        check("strobe_sd_rd", sd_rd, e.rd);
        check("strobe_sd_wr", sd_wr, e.wr);
        check("strobe_sd_lba", sd_lba, e.lba);
        strobe_cyc = cyc;
        cur_lba    = e.lba;
        cur_valid  = 1;
      end
      EV_NEXT: check("next_sectors_done", sectors_done, e.scount);
      EV_DONE: begin
        check("done_sectors_done", sectors_done, e.scount);
        check("done_err", err, e.err);
        check("done_strobes_low", {sd_rd, sd_wr}, 4'b0000);
        if (e.dly >= 0) check("done_delay_from_strobe", cyc - strobe_cyc, e.dly);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (reset) begin
      strobe_prev = 0;
      cur_valid   = 0;
    end else begin
      if (busy)        observe(EV_BUSY);
      if (dma_sec_ack) observe(EV_ACK);
      if ((sd_rd | sd_wr) != 2'b00 && !strobe_prev) observe(EV_STROBE);
      if (next)        observe(EV_NEXT);
      if (done)        observe(EV_DONE);
      if (next && done) begin
        checks++; errors++;
        $display("FAIL next_done_same_cycle actual=both required=exclusive (cycle %0d)", cyc);
      end
      if (sd_done && cur_valid) begin
        check("sd_lba_stable_to_sd_done", sd_lba, cur_lba);
        cur_valid = 0;
      end
      strobe_prev = (sd_rd | sd_wr) != 2'b00;
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_dly();
    return (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 5));
  endfunction

  task automatic pulse_ack();
    dma_sec_ack = 1'b1;
    tick();
    dma_sec_ack = 1'b0;
  endtask

  // which: 0 = busy, 1 = any SD strobe, 2 = next or done
  task automatic wait_cond(input int which, input int limit, input string name, output bit ok);
    ok = 0;
    for (int k = 0; k < limit; k++) begin
      tick();
      case (which)
        0:       ok = busy;
        1:       ok = (sd_rd | sd_wr) != 2'b00;
        default: ok = next | done;
      endcase
      if (ok) return;
    end
    checks++; errors++;
    $display("FAIL wait_%s actual=no_event required=event_within_%0d_cycles (cycle %0d)",
             name, limit, cyc);
  endtask

  task automatic recover();
    reset = 1'b1;
    req_rd = 2'b00; req_wr = 2'b00;
    sd_busy = 1'b0; sd_done = 1'b0; dma_sec_ack = 1'b0; dma_scnt_zero = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Reference rule for picking the request that wins.
  function automatic void arbitrate(input logic [1:0] rdm, input logic [1:0] wrm,
                                    output bit is_rd, output bit unit);
    is_rd = (rdm != 2'b00);
    unit  = is_rd ? !rdm[0] : !wrm[0];
  endfunction

  // One complete transfer. scnt_at > 0 raises dma_scnt_zero from sector
  // scnt_at on; lost_ack adds a DMA ack in the same cycle as sd_done (reads);
  // holdoff presents competing requests in NEXT_WAIT; no_sd_busy starves the
  // SD acceptance so that the watchdog fires.
  task automatic run_transfer(input logic [1:0] rdm, input logic [1:0] wrm,
                              input logic [31:0] lba, input logic [15:0] len,
                              input int scnt_at, input bit lost_ack,
                              input bit holdoff, input bit no_sd_busy);
    bit         is_rd, unit, ok;
    logic [1:0] mask;
    int         n;
    arbitrate(rdm, wrm, is_rd, unit);
    mask = unit ? 2'b10 : 2'b01;
    n = int'(len);
    if (scnt_at > 0 && scnt_at < n) n = scnt_at;

    // Expected event sequence.
    exp_q.push_back(mk(EV_BUSY, 0, 0, 0, 0, 0, -1));
    if (len == 0) exp_q.push_back(mk(EV_DONE, 0, 0, 0, 0, 0, -1));
    for (int i = 0; i < n; i++) begin
      if (!is_rd) exp_q.push_back(mk(EV_ACK, 0, 0, 0, 0, 0, -1));
      exp_q.push_back(mk(EV_STROBE, is_rd ? mask : 2'b00, is_rd ? 2'b00 : mask,
                         lba + 32'(i), 0, 0, -1));
      if (no_sd_busy) begin
        exp_q.push_back(mk(EV_DONE, 0, 0, 0, 16'(i), 1, (1 << TW) - 1));
        break;
      end
      if (is_rd && lost_ack) exp_q.push_back(mk(EV_ACK, 0, 0, 0, 0, 0, -1));
      if (is_rd)             exp_q.push_back(mk(EV_ACK, 0, 0, 0, 0, 0, -1));
      if (i + 1 < n) begin
        exp_q.push_back(mk(EV_NEXT, 0, 0, 0, 16'(i + 1), 0, -1));
        exp_q.push_back(mk(EV_BUSY, 0, 0, 0, 16'(i + 1), 0, -1));
      end else begin
        exp_q.push_back(mk(EV_DONE, 0, 0, 0, 16'(n), 0, -1));
      end
    end

    // Drive upstream and back end.
    req_rd = rdm; req_wr = wrm; req_lba = lba; req_length = len;
    wait_cond(0, 10, "busy", ok);
    req_rd = 2'b00; req_wr = 2'b00;
    if (!ok) begin recover(); return; end
    if (len == 0) begin repeat (3) tick(); return; end

    for (int i = 0; i < n; i++) begin
      if (scnt_at > 0 && i + 1 >= scnt_at) dma_scnt_zero = 1'b1;
      if (!is_rd) begin
        repeat (rnd_dly()) tick();
        pulse_ack();
      end
      wait_cond(1, 10, "strobe", ok);
      if (!ok) begin recover(); return; end
      if (no_sd_busy) begin
        wait_cond(2, 100, "watchdog_done", ok);
        repeat (2) tick();
        check("timeout_strobes_dropped", {sd_rd, sd_wr}, 4'b0000);
        check("timeout_err_sticky", err, 1'b1);
        dma_scnt_zero = 1'b0;
        return;
      end
      repeat (rnd_dly()) tick();
      sd_busy = 1'b1; tick(); sd_busy = 1'b0;
      repeat (rnd_dly()) tick();
      sd_done = 1'b1;
      if (is_rd && lost_ack) dma_sec_ack = 1'b1;
      tick();
      sd_done = 1'b0; dma_sec_ack = 1'b0;
      if (is_rd) begin
        repeat (rnd_dly()) tick();
        pulse_ack();
      end
      wait_cond(2, 10, "next_or_done", ok);
      if (!ok) begin recover(); return; end
      if (i + 1 < n) begin
        if (holdoff) begin
          req_rd = is_rd ? ~mask : 2'b11;
          req_wr = is_rd ? 2'b11 : ~mask;
          repeat (4) tick();
          req_rd = 2'b00; req_wr = 2'b00;
        end
        if (is_rd) req_rd = mask; else req_wr = mask;
        req_lba    = lba + 32'(i + 1);
        req_length = len - 16'(i + 1);
        wait_cond(0, 10, "busy_cont", ok);
        req_rd = 2'b00; req_wr = 2'b00;
        if (!ok) begin recover(); return; end
      end
    end
    dma_scnt_zero = 1'b0;
    repeat (2) tick();
  endtask

  // Reset while the SD transfer is in flight; a late sd_done must be ignored.
  task automatic reset_in_xfer();
    bit ok;
    exp_q.push_back(mk(EV_BUSY, 0, 0, 0, 0, 0, -1));
    exp_q.push_back(mk(EV_STROBE, 2'b01, 2'b00, 32'd500, 0, 0, -1));
    req_rd = 2'b01; req_lba = 32'd500; req_length = 16'd2;
    wait_cond(0, 10, "busy_rst", ok);
    req_rd = 2'b00;
    wait_cond(1, 10, "strobe_rst", ok);
    sd_busy = 1'b1; tick(); sd_busy = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_mid_strobes", {sd_rd, sd_wr}, 4'b0000);
    check("rst_mid_sectors_done", sectors_done, 16'd0);
    check("rst_mid_sd_lba", sd_lba, 32'd0);
    sd_done = 1'b1; tick(); sd_done = 1'b0;
    repeat (10) tick();
    check("rst_mid_no_pending_events", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    reset = 1'b1;
    req_rd = 2'b00; req_wr = 2'b00; req_lba = '0; req_length = '0;
    sd_busy = 1'b0; sd_done = 1'b0; dma_sec_ack = 1'b0; dma_scnt_zero = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_next_done", {next, done}, 2'b00);
    check("reset_err", err, 1'b0);
    check("reset_strobes", {sd_rd, sd_wr}, 4'b0000);
    check("reset_sd_lba", sd_lba, 32'd0);
    check("reset_sectors_done", sectors_done, 16'd0);

    // Stray back-end pulses in IDLE: only the ack itself is seen.
    exp_q.push_back(mk(EV_ACK, 0, 0, 0, 0, 0, -1));
    sd_done = 1'b1; dma_sec_ack = 1'b1; tick();
    sd_done = 1'b0; dma_sec_ack = 1'b0;
    repeat (3) tick();

    fixed_dly = 5;
    run_transfer(2'b01, 2'b00, 32'd100, 16'd3, 0, 0, 0, 0);        // read unit0 x3
    run_transfer(2'b00, 2'b10, 32'd7,   16'd1, 0, 0, 0, 0);        // write unit1 x1
    fixed_dly = -1;
    run_transfer(2'b11, 2'b01, 32'd40,  16'd2, 0, 0, 0, 0);        // arbitration
    run_transfer(2'b00, 2'b01, 32'd9,   16'd0, 0, 0, 0, 0);        // zero length
    run_transfer(2'b10, 2'b00, 32'd200, 16'd4, 2, 0, 0, 0);        // DMA count hits zero
    run_transfer(2'b01, 2'b00, 32'd300, 16'd2, 0, 0, 0, 1);        // watchdog
    repeat (5) tick();
    check("err_sticky_in_idle", err, 1'b1);
    run_transfer(2'b10, 2'b00, 32'd600, 16'd2, 0, 1, 0, 0);        // lost ack, clears err
    run_transfer(2'b00, 2'b01, 32'd700, 16'd3, 0, 0, 1, 0);        // hold-off, write
    run_transfer(2'b01, 2'b00, 32'hFFFF_FFFE, 16'd3, 0, 0, 1, 0);  // hold-off, read, LBA wrap
    reset_in_xfer();

    for (int t = 0; t < 30; t++) begin
      logic [1:0]  rdm, wrm;
      logic [15:0] len;
      do begin
        rdm = 2'($urandom_range(0, 3));
        wrm = 2'($urandom_range(0, 3));
      end while ((rdm | wrm) == 2'b00);
      len = 16'($urandom_range(0, 4));
      run_transfer(rdm, wrm, $urandom, len, int'($urandom_range(0, int'(len))),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (5) tick();
    check("all_expected_events_seen", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=still_running required=finished");
    $fatal(1, "time limit");
  end

endmodule
